// File: rtl/sys1_pkg.sv
// Shared types and constants for the SEGA System 1 download sequencer.
package sys1_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] IDX_ROM     = 8'd0;
  localparam logic [7:0] IDX_MODE    = 8'd1;
  localparam logic [7:0] IDX_DSW     = 8'd254;
  localparam logic [7:0] DSW_DEFAULT = 8'hFF;

endpackage

// File: rtl/sys1_rom_loader_if.sv
// hps_io download bus plus the ready/valid ROM write port towards the core.
interface sys1_rom_loader_if #(
  parameter int ADDR_W = 25
);

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              rom_valid;
  logic              rom_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, rom_ready,
    input  ioctl_wait, rom_valid, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, rom_ready,
    output ioctl_wait, rom_valid, rom_addr, rom_data
  );

endinterface

// File: rtl/sys1_fwft_fifo.sv
// First-word fall-through FIFO; the head is read straight from the storage registers.
module sys1_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, power-of-two wrapping pointers and occupancy
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_r + {{PTR_W{1'b0}}, push_ok_s} - {{PTR_W{1'b0}}, pop_ok_s};
    end
  end

endmodule

// File: rtl/sys1_rom_loader_chk.sv
// Simulation checks: stable ROM head under backpressure, sticky overflow, bounded occupancy.
module sys1_rom_loader_chk #(
  parameter int ADDR_W = 25,
  parameter int CNT_W  = 3,
  parameter int DEPTH  = 4
) (
  input logic              clk_sys,
  input logic              reset,
  input logic              overflow,
  input logic              rom_valid,
  input logic              rom_ready,
  input logic [ADDR_W-1:0] rom_addr,
  input logic [7:0]        rom_data,
  input logic [CNT_W-1:0]  count
);

  logic              stall_r;
  logic              ovf_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        data_r;

  // Snapshot of the previous cycle's handshake and head
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stall_r <= 1'b0;
      ovf_r   <= 1'b0;
      addr_r  <= '0;
      data_r  <= 8'h00;
    end else begin
      stall_r <= rom_valid & ~rom_ready;
      ovf_r   <= overflow;
      addr_r  <= rom_addr;
      data_r  <= rom_data;
    end
  end

  // Evaluated mid-cycle so every register has settled
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (stall_r) begin
        assert (rom_valid && rom_addr == addr_r && rom_data == data_r)
          else $error("rom head changed while stalled");
      end
      assert (!(ovf_r && !overflow)) else $error("overflow flag cleared");
      assert (count <= CNT_W'(DEPTH)) else $error("fifo occupancy out of range");
    end
  end

endmodule

// File: rtl/sys1_rom_loader.sv
// Sequences hps_io downloads into SEGA System 1: ROM FIFO, SYSMODE/DIP registers, core reset.
module sys1_rom_loader
  import sys1_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ADDR_W      = 25
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             user_rst,
  sys1_rom_loader_if.slave bus,
  output logic [7:0]       sysmode,
  output logic [7:0]       dsw0,
  output logic [7:0]       dsw1,
  output logic             core_rst,
  output logic             busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int FW     = ADDR_W + 8;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LVL    = CNT_W'(FIFO_DEPTH - 1);

  state_e            state_r, state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic              dl_prev_r, dl_rise_s, dl_fall_s;
  logic              rom_push_s, rom_pop_s, push_ok_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s, count_nxt_s;
  logic [FW-1:0]     head_s;
  logic              overflow_r, ioctl_wait_r, core_rst_r, busy_r;
  logic [7:0]        sysmode_r, dsw0_r, dsw1_r;

  assign dl_rise_s   = bus.ioctl_download & ~dl_prev_r;
  assign dl_fall_s   = ~bus.ioctl_download & dl_prev_r;
  assign rom_push_s  = bus.ioctl_wr & (bus.ioctl_index == IDX_ROM);
  assign rom_pop_s   = ~fifo_empty_s & bus.rom_ready;
  assign push_ok_s   = rom_push_s & (~fifo_full_s | rom_pop_s);
  assign count_nxt_s = fifo_count_s + {{(CNT_W-1){1'b0}}, push_ok_s}
                                    - {{(CNT_W-1){1'b0}}, rom_pop_s};

  sys1_fwft_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .rst     (reset),
    .push    (rom_push_s),
    .pop     (rom_pop_s),
    .wdata   ({bus.ioctl_addr, bus.ioctl_dout}),
    .rdata   (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign bus.rom_valid  = ~fifo_empty_s;
  assign bus.rom_addr   = head_s[FW-1:8];
  assign bus.rom_data   = head_s[7:0];
  assign bus.ioctl_wait = ioctl_wait_r;
  assign sysmode        = sysmode_r;
  assign dsw0           = dsw0_r;
  assign dsw1           = dsw1_r;
  assign core_rst       = core_rst_r;
  assign busy           = busy_r;

  // Download edge detect, backpressure, debug overflow and config bytes
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev_r    <= 1'b0;
      ioctl_wait_r <= 1'b0;
      overflow_r   <= 1'b0;
      sysmode_r    <= 8'h00;
      dsw0_r       <= DSW_DEFAULT;
      dsw1_r       <= DSW_DEFAULT;
    end else begin
      dl_prev_r    <= bus.ioctl_download;
      // One spare entry absorbs a strobe already issued before hps_io sees the wait.
      ioctl_wait_r <= (count_nxt_s >= WAIT_LVL);
      if (rom_push_s && fifo_full_s && !rom_pop_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.ioctl_wr && bus.ioctl_index == IDX_MODE && bus.ioctl_addr == '0) begin
        sysmode_r <= bus.ioctl_dout;
      end
      if (bus.ioctl_wr && bus.ioctl_index == IDX_DSW && bus.ioctl_addr[ADDR_W-1:3] == '0) begin
        case (bus.ioctl_addr[2:0])
          3'd0:    dsw0_r <= bus.ioctl_dout;
          3'd1:    dsw1_r <= bus.ioctl_dout;
          default: ;
        endcase
      end
    end
  end

  // State register, hold counter and registered reset/busy outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r    <= HOLD;
      hold_cnt_r <= HOLD_RELOAD;
      core_rst_r <= 1'b1;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      core_rst_r <= (state_nxt_s != RUN);
      busy_r     <= (state_nxt_s != RUN);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      RUN: begin
        if (dl_rise_s && bus.ioctl_index == IDX_ROM) begin
          state_nxt_s = LOAD;
        end else if (user_rst) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = HOLD_RELOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LOAD: begin
        if (dl_fall_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN: begin
        if (dl_rise_s) begin
          state_nxt_s = LOAD;
        end else if (fifo_empty_s) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = HOLD_RELOAD;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HOLD: begin
        if (dl_rise_s) begin
          state_nxt_s = LOAD;
        end else if (user_rst) begin
          hold_cnt_nxt_s = HOLD_RELOAD;
        end else if (hold_cnt_r == '0) begin
          state_nxt_s = RUN;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 1'b1;
        end
      end
      default: begin
        state_nxt_s    = HOLD;
        hold_cnt_nxt_s = HOLD_RELOAD;
      end
    endcase
  end

  sys1_rom_loader_chk #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(FIFO_DEPTH)) u_chk (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .overflow  (overflow_r),
    .rom_valid (bus.rom_valid),
    .rom_ready (bus.rom_ready),
    .rom_addr  (bus.rom_addr),
    .rom_data  (bus.rom_data),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_sys1_rom_loader.sv
// Directed bench for sys1_rom_loader with hand-computed expectations.
module tb_sys1_rom_loader;
  import sys1_pkg::*;

  localparam int ADDR_W = 25;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_rst;
  logic [7:0] sysmode, dsw0, dsw1;
  logic       core_rst, busy;
  int         checks = 0;
  int         errors = 0;

  sys1_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  sys1_rom_loader #(.FIFO_DEPTH(4), .HOLD_CYCLES(16), .ADDR_W(ADDR_W)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .user_rst (user_rst),
    .bus      (bus),
    .sysmode  (sysmode),
    .dsw0     (dsw0),
    .dsw1     (dsw1),
    .core_rst (core_rst),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr    = 1'b0;
  endtask

  // Cycles until core_rst drops, bounded so a stuck reset still ends the run.
  task automatic wait_core_release(output int n);
    n = 0;
    while (core_rst === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    reset              = 1'b1;
    user_rst           = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;
    bus.rom_ready      = 1'b1;
    repeat (3) tick();

    check_eq("rst_wait", bus.ioctl_wait, 1'b0);
    check_eq("rst_valid", bus.rom_valid, 1'b0);
    check_eq("rst_addr", bus.rom_addr, 25'd0);
    check_eq("rst_data", bus.rom_data, 8'h00);
    check_eq("rst_sysmode", sysmode, 8'h00);
    check_eq("rst_dsw0", dsw0, 8'hFF);
    check_eq("rst_dsw1", dsw1, 8'hFF);
    check_eq("rst_core_rst", core_rst, 1'b1);
    check_eq("rst_busy", busy, 1'b1);

    // Power-up: 16 hold cycles, then RUN
    reset = 1'b0;
    wait_core_release(n);
    check_eq("powerup_hold", n, 32'd16);
    check_eq("powerup_busy", busy, 1'b0);

    // ROM download, sink always ready, strobe every 4 cycles
    bus.ioctl_index    = IDX_ROM;
    bus.ioctl_download = 1'b1;
    tick();
    check_eq("load_core_rst", core_rst, 1'b1);
    for (int i = 0; i < 16; i++) begin
      strobe(IDX_ROM, ADDR_W'(i), 8'(i));
      check_eq("dl_valid", bus.rom_valid, 1'b1);
      check_eq("dl_addr", bus.rom_addr, i);
      check_eq("dl_data", bus.rom_data, i);
      tick();
      check_eq("dl_popped", bus.rom_valid, 1'b0);
      check_eq("dl_core_rst", core_rst, 1'b1);
      tick();
      tick();
    end
    check_eq("dl_wait", bus.ioctl_wait, 1'b0);
    // falling edge -> DRAIN (1), empty -> HOLD (1), then 16 hold cycles
    bus.ioctl_download = 1'b0;
    wait_core_release(n);
    check_eq("dl_release", n, 32'd18);

    // Backpressure: four back-to-back strobes with the sink stalled
    bus.rom_ready      = 1'b0;
    bus.ioctl_index    = IDX_ROM;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(IDX_ROM, ADDR_W'(i), 8'h50 + 8'(i));
      check_eq("bp_wait", bus.ioctl_wait, (i >= 2) ? 1'b1 : 1'b0);
      check_eq("bp_valid", bus.rom_valid, 1'b1);
      check_eq("bp_head_addr", bus.rom_addr, 25'd0);
      check_eq("bp_head_data", bus.rom_data, 8'h50);
    end
    tick();
    tick();
    check_eq("bp_stable_addr", bus.rom_addr, 25'd0);
    check_eq("bp_stable_data", bus.rom_data, 8'h50);
    check_eq("bp_count", dut.u_fifo.count_r, 3'd4);
    check_eq("bp_overflow", dut.overflow_r, 1'b0);

    // Full FIFO: push and pop on the same edge
    bus.rom_ready = 1'b1;
    strobe(IDX_ROM, 25'd4, 8'h54);
    check_eq("full_count", dut.u_fifo.count_r, 3'd4);
    check_eq("full_overflow", dut.overflow_r, 1'b0);
    check_eq("full_wait", bus.ioctl_wait, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      check_eq("drain_valid", bus.rom_valid, 1'b1);
      check_eq("drain_addr", bus.rom_addr, j);
      check_eq("drain_data", bus.rom_data, 8'h50 + 8'(j));
      tick();
    end
    check_eq("drain_empty", bus.rom_valid, 1'b0);
    check_eq("drain_wait", bus.ioctl_wait, 1'b0);
    check_eq("drain_overflow", dut.overflow_r, 1'b0);
    bus.ioctl_download = 1'b0;
    wait_core_release(n);
    check_eq("bp_release", n, 32'd18);

    // DIP switches and SYSMODE load live without resetting the core
    bus.ioctl_index    = IDX_DSW;
    bus.ioctl_download = 1'b1;
    tick();
    check_eq("dsw_core_rst", core_rst, 1'b0);
    strobe(IDX_DSW, 25'd0, 8'h3C);
    strobe(IDX_DSW, 25'd1, 8'hA5);
    strobe(IDX_DSW, 25'd5, 8'h11);
    strobe(IDX_DSW, 25'd8, 8'h77);
    bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_index    = IDX_MODE;
    bus.ioctl_download = 1'b1;
    tick();
    strobe(IDX_MODE, 25'd0, 8'h06);
    strobe(IDX_MODE, 25'd1, 8'h99);
    strobe(8'd7, 25'd0, 8'hEE);
    bus.ioctl_download = 1'b0;
    tick();
    check_eq("cfg_dsw0", dsw0, 8'h3C);
    check_eq("cfg_dsw1", dsw1, 8'hA5);
    check_eq("cfg_sysmode", sysmode, 8'h06);
    check_eq("cfg_core_rst", core_rst, 1'b0);
    check_eq("cfg_busy", busy, 1'b0);
    check_eq("cfg_no_rom", bus.rom_valid, 1'b0);

    // Asynchronous reset with two entries queued
    bus.rom_ready      = 1'b0;
    bus.ioctl_index    = IDX_ROM;
    bus.ioctl_download = 1'b1;
    tick();
    strobe(IDX_ROM, 25'h20, 8'hE0);
    strobe(IDX_ROM, 25'h21, 8'hE1);
    check_eq("ar_pre_valid", bus.rom_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_valid", bus.rom_valid, 1'b0);
    check_eq("ar_core_rst", core_rst, 1'b1);
    check_eq("ar_busy", busy, 1'b1);
    check_eq("ar_count", dut.u_fifo.count_r, 3'd0);
    check_eq("ar_state", dut.state_r, HOLD);
    check_eq("ar_dsw0", dsw0, 8'hFF);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    bus.ioctl_download = 1'b1;
    tick();
    strobe(IDX_ROM, 25'h40, 8'h7E);
    check_eq("ar_new_addr", bus.rom_addr, 25'h40);
    check_eq("ar_new_data", bus.rom_data, 8'h7E);
    bus.rom_ready = 1'b1;
    tick();
    check_eq("ar_only_new", bus.rom_valid, 1'b0);
    check_eq("ar_core_rst_load", core_rst, 1'b1);

    // Overflow: fifth push into a stalled full FIFO is dropped
    bus.rom_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(IDX_ROM, 25'h60 + ADDR_W'(i), 8'h80 + 8'(i));
    end
    check_eq("ovf_flag", dut.overflow_r, 1'b1);
    check_eq("ovf_count", dut.u_fifo.count_r, 3'd4);
    bus.rom_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq("ovf_addr", bus.rom_addr, 25'h60 + ADDR_W'(j));
      check_eq("ovf_data", bus.rom_data, 8'h80 + 8'(j));
      tick();
    end
    check_eq("ovf_empty", bus.rom_valid, 1'b0);
    check_eq("ovf_sticky", dut.overflow_r, 1'b1);
    bus.ioctl_download = 1'b0;
    wait_core_release(n);
    check_eq("ovf_release", n, 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
